// File: rtl/axi_lite_write_arbiter.sv
// -----------------------------------------------------------------------------
// AxiLiteWriteArbiter
//
// Purpose:
//   Shares one AXI-Lite write port between two local requesters. Each
//   requester posts one address/data/strobe write at a time. The block picks a
//   requester round-robin, drives the AW and W channels, waits for the B
//   response, and then hands that response back to the requester it granted.
//   Only one write is in flight at any time.
//
// Ports:
//   aclk, areset             clock and synchronous active-high reset
//   reqN_address/data/strobe requester payload, held stable while reqN_valid
//   reqN_valid / reqN_ready  request handshake; ready is a one-cycle pulse
//   reqN_response(_valid)    B response returned as a one-cycle pulse
//   m_write_address*         manager AW channel
//   m_write_data*            manager W channel
//   m_write_response*        manager B channel
//   grant_id                 requester currently or most recently granted
//   busy                     high whenever a write is in progress
// -----------------------------------------------------------------------------
module axi_lite_write_arbiter #(
   parameter int ADDRESS_SIZE = 32,
   parameter int DATA_SIZE    = 32,
   parameter int WRITE_STROBE = DATA_SIZE / 8
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDRESS_SIZE-1:0] req0_address,
   input  logic [DATA_SIZE-1:0]    req0_data,
   input  logic [WRITE_STROBE-1:0] req0_strobe,
   input  logic                    req0_valid,
   output logic                    req0_ready,
   output logic [1:0]              req0_response,
   output logic                    req0_response_valid,
   input  logic [ADDRESS_SIZE-1:0] req1_address,
   input  logic [DATA_SIZE-1:0]    req1_data,
   input  logic [WRITE_STROBE-1:0] req1_strobe,
   input  logic                    req1_valid,
   output logic                    req1_ready,
   output logic [1:0]              req1_response,
   output logic                    req1_response_valid,
   output logic [ADDRESS_SIZE-1:0] m_write_address,
   output logic                    m_write_address_valid,
   input  logic                    m_write_address_ready,
   output logic [DATA_SIZE-1:0]    m_write_data,
   output logic [WRITE_STROBE-1:0] m_write_data_strobe,
   output logic                    m_write_data_valid,
   input  logic                    m_write_data_ready,
   input  logic [1:0]              m_write_response,
   input  logic                    m_write_response_valid,
   output logic                    m_write_response_ready,
   output logic                    grant_id,
   output logic                    busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] RESP  = 2'd2;

   logic [1:0]              state_q, state_d;
   logic                    lastGrant_q, lastGrant_d;
   logic                    grantId_q, grantId_d;
   logic                    busy_q, busy_d;
   logic                    awValid_q, awValid_d;
   logic                    wValid_q, wValid_d;
   logic                    bReady_q, bReady_d;
   logic [ADDRESS_SIZE-1:0] address_q, address_d;
   logic [DATA_SIZE-1:0]    data_q, data_d;
   logic [WRITE_STROBE-1:0] strobe_q, strobe_d;
   logic                    req0Ready_q, req0Ready_d;
   logic                    req1Ready_q, req1Ready_d;
   logic [1:0]              resp0_q, resp0_d;
   logic [1:0]              resp1_q, resp1_d;
   logic                    resp0Valid_q, resp0Valid_d;
   logic                    resp1Valid_q, resp1Valid_d;
   logic                    winner;
   logic                    awDoneNow;
   logic                    wDoneNow;

   // Next-state logic. A channel counts as done if its valid already dropped
   // or its handshake completes on this edge, so bready rises in the cycle
   // right after the later of the two handshakes.
   always_comb begin
      state_d      = state_q;
      lastGrant_d  = lastGrant_q;
      grantId_d    = grantId_q;
      awValid_d    = awValid_q;
      wValid_d     = wValid_q;
      bReady_d     = bReady_q;
      address_d    = address_q;
      data_d       = data_q;
      strobe_d     = strobe_q;
      req0Ready_d  = 1'b0;
      req1Ready_d  = 1'b0;
      resp0_d      = resp0_q;
      resp1_d      = resp1_q;
      resp0Valid_d = 1'b0;
      resp1Valid_d = 1'b0;
      awDoneNow    = !awValid_q || m_write_address_ready;
      wDoneNow     = !wValid_q || m_write_data_ready;

      // On a tie the requester not served last time wins; otherwise the lone
      // valid requester wins.
      if (req0_valid && req1_valid) begin
         winner = ~lastGrant_q;
      end else begin
         winner = req1_valid;
      end

      case (state_q)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               grantId_d   = winner;
               req0Ready_d = ~winner;
               req1Ready_d = winner;
               address_d   = winner ? req1_address : req0_address;
               data_d      = winner ? req1_data    : req0_data;
               strobe_d    = winner ? req1_strobe  : req0_strobe;
               awValid_d   = 1'b1;
               wValid_d    = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (m_write_address_ready) begin
               awValid_d = 1'b0;
            end
            if (m_write_data_ready) begin
               wValid_d = 1'b0;
            end
            if (awDoneNow && wDoneNow) begin
               bReady_d = 1'b1;
               state_d  = RESP;
            end
         end
         RESP: begin
            if (m_write_response_valid) begin
               bReady_d = 1'b0;
               if (grantId_q) begin
                  resp1_d      = m_write_response;
                  resp1Valid_d = 1'b1;
               end else begin
                  resp0_d      = m_write_response;
                  resp0Valid_d = 1'b1;
               end
               lastGrant_d = grantId_q;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State registers. Reset abandons any write in flight without a response,
   // and last grant returns to 1 so requester 0 wins the first tie.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= IDLE;
         lastGrant_q  <= 1'b1;
         grantId_q    <= 1'b0;
         busy_q       <= 1'b0;
         awValid_q    <= 1'b0;
         wValid_q     <= 1'b0;
         bReady_q     <= 1'b0;
         address_q    <= '0;
         data_q       <= '0;
         strobe_q     <= '0;
         req0Ready_q  <= 1'b0;
         req1Ready_q  <= 1'b0;
         resp0_q      <= 2'b00;
         resp1_q      <= 2'b00;
         resp0Valid_q <= 1'b0;
         resp1Valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lastGrant_q  <= lastGrant_d;
         grantId_q    <= grantId_d;
         busy_q       <= busy_d;
         awValid_q    <= awValid_d;
         wValid_q     <= wValid_d;
         bReady_q     <= bReady_d;
         address_q    <= address_d;
         data_q       <= data_d;
         strobe_q     <= strobe_d;
         req0Ready_q  <= req0Ready_d;
         req1Ready_q  <= req1Ready_d;
         resp0_q      <= resp0_d;
         resp1_q      <= resp1_d;
         resp0Valid_q <= resp0Valid_d;
         resp1Valid_q <= resp1Valid_d;
      end
   end

   assign req0_ready             = req0Ready_q;
   assign req1_ready             = req1Ready_q;
   assign req0_response          = resp0_q;
   assign req1_response          = resp1_q;
   assign req0_response_valid    = resp0Valid_q;
   assign req1_response_valid    = resp1Valid_q;
   assign m_write_address        = address_q;
   assign m_write_address_valid  = awValid_q;
   assign m_write_data           = data_q;
   assign m_write_data_strobe    = strobe_q;
   assign m_write_data_valid     = wValid_q;
   assign m_write_response_ready = bReady_q;
   assign grant_id               = grantId_q;
   assign busy                   = busy_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// -----------------------------------------------------------------------------
// TbAxiLiteWriteArbiter
//
// Directed bench for the two-requester AXI-Lite write arbiter. A small manager
// model answers AW/W/B with configurable wait cycles, and a monitor counts
// pulses, valid-high cycles and protocol slips so each test can compare
// hand-computed expectations against the observed behaviour.
// -----------------------------------------------------------------------------
module tb_axi_lite_write_arbiter;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] req0_address, req1_address;
   logic [31:0] req0_data, req1_data;
   logic [3:0]  req0_strobe, req1_strobe;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [1:0]  req0_response, req1_response;
   logic        req0_response_valid, req1_response_valid;
   logic [31:0] m_write_address;
   logic        m_write_address_valid, m_write_address_ready;
   logic [31:0] m_write_data;
   logic [3:0]  m_write_data_strobe;
   logic        m_write_data_valid, m_write_data_ready;
   logic [1:0]  m_write_response;
   logic        m_write_response_valid, m_write_response_ready;
   logic        grant_id;
   logic        busy;

   axi_lite_write_arbiter #(
      .ADDRESS_SIZE(32),
      .DATA_SIZE(32),
      .WRITE_STROBE(4)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .req0_address(req0_address),
      .req0_data(req0_data),
      .req0_strobe(req0_strobe),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_response(req0_response),
      .req0_response_valid(req0_response_valid),
      .req1_address(req1_address),
      .req1_data(req1_data),
      .req1_strobe(req1_strobe),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_response(req1_response),
      .req1_response_valid(req1_response_valid),
      .m_write_address(m_write_address),
      .m_write_address_valid(m_write_address_valid),
      .m_write_address_ready(m_write_address_ready),
      .m_write_data(m_write_data),
      .m_write_data_strobe(m_write_data_strobe),
      .m_write_data_valid(m_write_data_valid),
      .m_write_data_ready(m_write_data_ready),
      .m_write_response(m_write_response),
      .m_write_response_valid(m_write_response_valid),
      .m_write_response_ready(m_write_response_ready),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int passed = 0;

   // Manager model configuration
   int         awWait = 0;
   int         wWait = 0;
   int         bWait = 0;
   logic [1:0] bRespCfg = 2'b00;
   logic       strayB = 1'b0;

   // Monitor state
   int          r0Cnt = 0, r1Cnt = 0, p0Cnt = 0, p1Cnt = 0;
   int          awHigh = 0, wHigh = 0;
   int          stabErr = 0, overlapErr = 0, grantErr = 0;
   int          grantQ[$];
   logic        prevAw = 1'b0, prevW = 1'b0;
   logic [31:0] prevAddr = '0, prevData = '0;
   logic [3:0]  prevStrb = '0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Manager model: each ready/valid is raised after the configured number of
   // wait cycles, evaluated on the falling edge so it is stable at the posedge.
   // strayB injects a B valid while the arbiter is not waiting for one.
   initial begin
      int awCnt, wCnt, bCnt;
      awCnt = 0; wCnt = 0; bCnt = 0;
      m_write_address_ready  = 1'b0;
      m_write_data_ready     = 1'b0;
      m_write_response_valid = 1'b0;
      m_write_response       = 2'b00;
      forever begin
         @(negedge aclk);
         if (m_write_address_valid) begin
            if (awCnt >= awWait) m_write_address_ready = 1'b1;
            else begin m_write_address_ready = 1'b0; awCnt++; end
         end else begin
            m_write_address_ready = 1'b0; awCnt = 0;
         end
         if (m_write_data_valid) begin
            if (wCnt >= wWait) m_write_data_ready = 1'b1;
            else begin m_write_data_ready = 1'b0; wCnt++; end
         end else begin
            m_write_data_ready = 1'b0; wCnt = 0;
         end
         if (m_write_response_ready) begin
            if (bCnt >= bWait) begin
               m_write_response_valid = 1'b1;
               m_write_response       = bRespCfg;
            end else begin
               m_write_response_valid = 1'b0;
               bCnt++;
            end
         end else begin
            m_write_response_valid = strayB;
            m_write_response       = strayB ? 2'b10 : 2'b00;
            bCnt = 0;
         end
      end
   end

   // Monitor, sampling shortly after each rising edge.
   initial begin
      forever begin
         @(posedge aclk);
         #2;
         if (req0_ready) begin r0Cnt++; grantQ.push_back(0); if (grant_id !== 1'b0) grantErr++; end
         if (req1_ready) begin r1Cnt++; grantQ.push_back(1); if (grant_id !== 1'b1) grantErr++; end
         if (req0_response_valid) p0Cnt++;
         if (req1_response_valid) p1Cnt++;
         if (m_write_address_valid) awHigh++;
         if (m_write_data_valid) wHigh++;
         if (m_write_address_valid && prevAw && m_write_address !== prevAddr) stabErr++;
         if (m_write_data_valid && prevW && (m_write_data !== prevData || m_write_data_strobe !== prevStrb)) stabErr++;
         if (m_write_response_ready && (m_write_address_valid || m_write_data_valid)) overlapErr++;
         prevAw   = m_write_address_valid;
         prevW    = m_write_data_valid;
         prevAddr = m_write_address;
         prevData = m_write_data;
         prevStrb = m_write_data_strobe;
      end
   end

   task automatic applyStimulus(input int id, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      if (id == 0) begin
         req0_address = addr; req0_data = data; req0_strobe = strb; req0_valid = 1'b1;
      end else begin
         req1_address = addr; req1_data = data; req1_strobe = strb; req1_valid = 1'b1;
      end
   endtask

   task automatic dropValid(input int id);
      if (id == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
   endtask

   task automatic waitReady(input int id, output int cyc, output logic seen);
      cyc = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge aclk);
         cyc++;
         seen = (id == 0) ? req0_ready : req1_ready;
      end
   endtask

   task automatic waitResp(input int id, output int cyc, output logic seen, output logic [1:0] resp);
      cyc = 0; seen = 1'b0; resp = 2'b00;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge aclk);
         cyc++;
         seen = (id == 0) ? req0_response_valid : req1_response_valid;
         resp = (id == 0) ? req0_response : req1_response;
      end
   endtask

   // One full write from a requester: post, wait for ready (capturing the
   // manager-side view in that cycle), drop valid, wait for the response.
   task automatic requestAndWait(input string tag, input int id, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 output int readyCyc, output int respCyc, output logic [1:0] resp,
                                 output logic [31:0] capAddr, output logic [31:0] capData,
                                 output logic [3:0] capStrb, output logic capGrant,
                                 output logic [1:0] capValids);
      logic seen;
      applyStimulus(id, addr, data, strb);
      waitReady(id, readyCyc, seen);
      checkOutput({tag, " ready seen"}, seen, 1);
      capAddr   = m_write_address;
      capData   = m_write_data;
      capStrb   = m_write_data_strobe;
      capGrant  = grant_id;
      capValids = {m_write_address_valid, m_write_data_valid};
      dropValid(id);
      waitResp(id, respCyc, seen, resp);
      checkOutput({tag, " response seen"}, seen, 1);
   endtask

   task automatic doReset();
      areset = 1'b1;
      repeat (2) @(negedge aclk);
      areset = 1'b0;
   endtask

   initial begin
      int          rc, pc, s0, s1, s2, s3, busyLow;
      logic [1:0]  rs;
      logic [31:0] ca, cd;
      logic [3:0]  cs;
      logic        cg, seen;
      logic [1:0]  cv;

      req0_address = '0; req0_data = '0; req0_strobe = '0; req0_valid = 1'b0;
      req1_address = '0; req1_data = '0; req1_strobe = '0; req1_valid = 1'b0;
      areset = 1'b1;
      repeat (2) @(negedge aclk);

      // Reset values while reset is held
      checkOutput("reset busy", busy, 0);
      checkOutput("reset grant_id", grant_id, 0);
      checkOutput("reset valids", {m_write_address_valid, m_write_data_valid, m_write_response_ready}, 0);
      checkOutput("reset pulses", {req0_ready, req1_ready, req0_response_valid, req1_response_valid}, 0);
      checkOutput("reset payload", {m_write_address, m_write_data, m_write_data_strobe}, 0);
      checkOutput("reset responses", {req0_response, req1_response}, 0);
      areset = 1'b0;
      @(negedge aclk);

      // Test 1: basic req0 write, zero-wait manager
      $display("[TB] test 1: single req0 write");
      s1 = r1Cnt; s2 = p1Cnt; s0 = p0Cnt;
      requestAndWait("t1", 0, 32'h0, 32'hDEADBEEF, 4'hF, rc, pc, rs, ca, cd, cs, cg, cv);
      checkOutput("t1 ready latency", rc, 1);
      checkOutput("t1 m address", ca, 32'h0);
      checkOutput("t1 m data", cd, 32'hDEADBEEF);
      checkOutput("t1 m strobe", cs, 4'hF);
      checkOutput("t1 grant_id", cg, 0);
      checkOutput("t1 m valids", cv, 2'b11);
      checkOutput("t1 response latency", pc, 2);
      checkOutput("t1 response", rs, 2'b00);
      checkOutput("t1 busy at response", busy, 0);
      checkOutput("t1 req0 response pulses", p0Cnt - s0, 1);
      checkOutput("t1 req1 ready pulses", r1Cnt - s1, 0);
      checkOutput("t1 req1 response pulses", p1Cnt - s2, 0);

      // Test 2: both requesters contend from reset, re-asserting after each response
      $display("[TB] test 2: round-robin contention");
      doReset();
      grantQ.delete();
      s0 = r0Cnt; s1 = r1Cnt; s2 = p0Cnt; s3 = p1Cnt;
      fork
         begin
            int a, b; logic [1:0] r, v; logic [31:0] x, y; logic [3:0] z; logic g;
            for (int i = 0; i < 2; i++)
               requestAndWait("t2 req0", 0, 32'h10 + i * 4, 32'hA000 + i, 4'hF, a, b, r, x, y, z, g, v);
         end
         begin
            int a, b; logic [1:0] r, v; logic [31:0] x, y; logic [3:0] z; logic g;
            for (int i = 0; i < 2; i++)
               requestAndWait("t2 req1", 1, 32'h20 + i * 4, 32'hB000 + i, 4'hF, a, b, r, x, y, z, g, v);
         end
      join
      checkOutput("t2 grant count", grantQ.size(), 4);
      if (grantQ.size() == 4) begin
         checkOutput("t2 grant order", {grantQ[0][0], grantQ[1][0], grantQ[2][0], grantQ[3][0]}, 4'b0101);
      end
      checkOutput("t2 req0 readies", r0Cnt - s0, 2);
      checkOutput("t2 req1 readies", r1Cnt - s1, 2);
      checkOutput("t2 req0 responses", p0Cnt - s2, 2);
      checkOutput("t2 req1 responses", p1Cnt - s3, 2);

      // Test 3: AW ready held off, W ready immediately
      $display("[TB] test 3: delayed AW ready");
      awWait = 2;
      @(negedge aclk);
      s0 = awHigh; s1 = wHigh;
      requestAndWait("t3", 0, 32'h40, 32'h55AA55AA, 4'h3, rc, pc, rs, ca, cd, cs, cg, cv);
      checkOutput("t3 aw high cycles", awHigh - s0, 3);
      checkOutput("t3 w high cycles", wHigh - s1, 1);
      checkOutput("t3 response latency", pc, 4);
      checkOutput("t3 response", rs, 2'b00);
      awWait = 0;

      // Test 4: req1 write answered with SLVERR
      $display("[TB] test 4: req1 write with SLVERR");
      bRespCfg = 2'b10;
      s0 = p0Cnt; s1 = p1Cnt;
      requestAndWait("t4", 1, 32'h4, 32'h12345678, 4'hF, rc, pc, rs, ca, cd, cs, cg, cv);
      checkOutput("t4 m address", ca, 32'h4);
      checkOutput("t4 m data", cd, 32'h12345678);
      checkOutput("t4 grant_id", cg, 1);
      checkOutput("t4 response", rs, 2'b10);
      checkOutput("t4 req1 response pulses", p1Cnt - s1, 1);
      checkOutput("t4 req0 response pulses", p0Cnt - s0, 0);
      bRespCfg = 2'b00;

      // Stray B valid while idle must be ignored
      $display("[TB] stray B valid while idle");
      s0 = p0Cnt; s1 = p1Cnt;
      strayB = 1'b1;
      repeat (3) @(negedge aclk);
      strayB = 1'b0;
      repeat (2) @(negedge aclk);
      checkOutput("stray B response pulses", (p0Cnt - s0) + (p1Cnt - s1), 0);
      checkOutput("stray B busy", busy, 0);

      // Test 5: B held off 10 cycles while req0 posts a second request
      $display("[TB] test 5: delayed B with pending request");
      bWait = 10;
      applyStimulus(0, 32'h80, 32'h0BADF00D, 4'hF);
      waitReady(0, rc, seen);
      checkOutput("t5 first ready seen", seen, 1);
      dropValid(0);
      applyStimulus(0, 32'h84, 32'h600DF00D, 4'hF);
      s0 = r0Cnt; s1 = p0Cnt;
      busyLow = 0; pc = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge aclk);
         pc++;
         seen = req0_response_valid;
         if (!seen && !busy) busyLow++;
      end
      checkOutput("t5 response seen", seen, 1);
      checkOutput("t5 response latency", pc, 12);
      checkOutput("t5 busy low cycles", busyLow, 0);
      checkOutput("t5 readies while busy", r0Cnt - s0, 0);
      checkOutput("t5 responses while busy", p0Cnt - s1, 1);
      bWait = 0;
      waitReady(0, rc, seen);
      checkOutput("t5 second ready seen", seen, 1);
      checkOutput("t5 second ready latency", rc, 1);
      checkOutput("t5 second m address", m_write_address, 32'h84);
      dropValid(0);
      waitResp(0, pc, seen, rs);
      checkOutput("t5 second response seen", seen, 1);
      checkOutput("t5 second response", rs, 2'b00);

      // Test 6: reset during ISSUE abandons the write
      $display("[TB] test 6: reset mid-transaction");
      awWait = 5;
      s0 = p0Cnt;
      applyStimulus(0, 32'hC0, 32'hFEEDFACE, 4'hF);
      waitReady(0, rc, seen);
      checkOutput("t6 ready seen", seen, 1);
      dropValid(0);
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      checkOutput("t6 m valids after reset", {m_write_address_valid, m_write_data_valid, m_write_response_ready}, 0);
      checkOutput("t6 busy after reset", busy, 0);
      checkOutput("t6 address after reset", m_write_address, 0);
      awWait = 0;
      repeat (8) @(negedge aclk);
      checkOutput("t6 no abandoned response", p0Cnt - s0, 0);
      requestAndWait("t6 req1", 1, 32'h8, 32'hCAFEF00D, 4'h3, rc, pc, rs, ca, cd, cs, cg, cv);
      checkOutput("t6 req1 m address", ca, 32'h8);
      checkOutput("t6 req1 grant_id", cg, 1);
      checkOutput("t6 req1 response latency", pc, 2);
      checkOutput("t6 req1 response", rs, 2'b00);

      // Accumulated protocol observations
      repeat (2) @(negedge aclk);
      checkOutput("payload stability slips", stabErr, 0);
      checkOutput("bready overlapping AW/W valid", overlapErr, 0);
      checkOutput("ready vs grant_id slips", grantErr, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global time bound so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d passed", passed, checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
